// File: rtl/alu_issue_queue_pkg.sv
// alu_issue_queue_pkg
//   Shared types for the ALU issue queue. It holds the bus structs exchanged
//   with dispatch, the bypass network and the ALU execute stage, and the
//   per-slot queue entry. It also provides small helpers that convert
//   between these structs.
package alu_issue_queue_pkg;

  localparam int IQ_ENTRIES_DEFAULT = 8;
  localparam int XLEN               = 32;
  localparam int PHY_REG_W          = 6;
  localparam int ROB_W              = 5;

  typedef logic [PHY_REG_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]      word_t;

  typedef struct packed {
    logic [3:0] we;
    reg_addr_t  phy_dest;
    word_t      result;
  } bypass_bus_t;

  typedef struct packed {
    word_t            inst;
    reg_addr_t        phy_dest;
    word_t            src1_value;
    word_t            src2_value;
    logic [ROB_W-1:0] rob_entry_num;
  } issue_to_execute_bus_t;

  typedef struct packed {
    word_t            inst;
    reg_addr_t        phy_dest;
    logic [ROB_W-1:0] rob_entry_num;
    reg_addr_t        src1_tag;
    logic             src1_ready;
    word_t            src1_value;
    reg_addr_t        src2_tag;
    logic             src2_ready;
    word_t            src2_value;
  } dispatch_to_iq_bus_t;

  typedef struct packed {
    logic             valid;
    word_t            inst;
    reg_addr_t        phy_dest;
    logic [ROB_W-1:0] rob_entry_num;
    reg_addr_t        src1_tag;
    logic             src1_ready;
    word_t            src1_value;
    reg_addr_t        src2_tag;
    logic             src2_ready;
    word_t            src2_value;
  } iq_entry_t;

  function automatic iq_entry_t entry_from_dispatch(input dispatch_to_iq_bus_t d);
    iq_entry_t e;
    e.valid         = 1'b1;
    e.inst          = d.inst;
    e.phy_dest      = d.phy_dest;
    e.rob_entry_num = d.rob_entry_num;
    e.src1_tag      = d.src1_tag;
    e.src1_ready    = d.src1_ready;
    e.src1_value    = d.src1_value;
    e.src2_tag      = d.src2_tag;
    e.src2_ready    = d.src2_ready;
    e.src2_value    = d.src2_value;
    return e;
  endfunction

  function automatic issue_to_execute_bus_t issue_from_entry(input iq_entry_t e);
    issue_to_execute_bus_t b;
    b.inst          = e.inst;
    b.phy_dest      = e.phy_dest;
    b.src1_value    = e.src1_value;
    b.src2_value    = e.src2_value;
    b.rob_entry_num = e.rob_entry_num;
    return b;
  endfunction

endpackage

// File: rtl/alu_issue_queue_cam.sv
// iq_wakeup_cam
//   Compares a vector of source tags against all bypass buses. For each
//   source it reports whether a bypass carries that tag this cycle and, if so,
//   the bypassed result. Tag 0 is the hard-wired zero register and never
//   matches. When several bypasses carry the same tag, the lowest bypass index
//   wins.
// Ports:
//   tags       in  NUM_SRC source tags
//   bypass_bus in  NUM_BYPASS wakeup buses; only we[0] qualifies a wakeup
//   hit        out per-source match flag
//   data       out per-source captured result (0 when no hit)
module iq_wakeup_cam
  import alu_issue_queue_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_BYPASS = 3
) (
  input  reg_addr_t   [NUM_SRC-1:0]    tags,
  input  bypass_bus_t [NUM_BYPASS-1:0] bypass_bus,
  output logic        [NUM_SRC-1:0]    hit,
  output word_t       [NUM_SRC-1:0]    data
);

  // The upper write-enable bits belong to other consumers of the bypass bus.
  logic [NUM_BYPASS-1:0] unused_we_hi;

  always_comb begin
    unused_we_hi = '0;
    for (int b = 0; b < NUM_BYPASS; b++) begin
      unused_we_hi[b] = ^bypass_bus[b].we[3:1];
    end
  end

  // Scan bypasses from the highest index down so that the lowest matching
  // index is the last one written.
  always_comb begin
    hit  = '0;
    data = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int b = NUM_BYPASS - 1; b >= 0; b--) begin
        if (bypass_bus[b].we[0] && (tags[s] != '0) &&
            (bypass_bus[b].phy_dest == tags[s])) begin
          hit[s]  = 1'b1;
          data[s] = bypass_bus[b].result;
        end
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Compacting data-capture issue queue in front of the ALU. Slot 0 always
//   holds the oldest instruction. Sources capture operands from the bypass
//   buses. The oldest fully ready entry moves into a registered output
//   toward the ALU, and the entries above it shift down by one.
// Optional build macro:
//   ALU_IQ_DIRECT_ISSUE_EN - a fully ready dispatch can go straight into the
//   output register when nothing in the queue is ready (1-cycle latency).
// Ports:
//   clk, resetn         clock and asynchronous active-low reset
//   flush               synchronous clear of entries and the output register
//   dispatch_valid      dispatch offers dispatch_inst
//   iq_allowin          queue has a free slot (registered occupancy)
//   dispatch_inst       instruction plus source tags/ready/value
//   bypass_bus          NUM_BYPASS wakeup/data buses
//   issue_to_alu_valid  output register holds an instruction
//   alu_allowin         ALU takes the output register this cycle
//   issue_inst          registered instruction and operands for the ALU
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int ENTRIES    = IQ_ENTRIES_DEFAULT,
  parameter int NUM_BYPASS = 3
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            flush,
  input  logic                            dispatch_valid,
  output logic                            iq_allowin,
  input  dispatch_to_iq_bus_t             dispatch_inst,
  input  bypass_bus_t [NUM_BYPASS-1:0]    bypass_bus,
  output logic                            issue_to_alu_valid,
  input  logic                            alu_allowin,
  output issue_to_execute_bus_t           issue_inst
);

  localparam int CNT_W = $clog2(ENTRIES + 1);

  iq_entry_t entries     [ENTRIES];
  iq_entry_t entries_nxt [ENTRIES];
  // One extra all-zero slot so the top entry can shift in "empty".
  iq_entry_t woken       [ENTRIES+1];
  iq_entry_t disp_woken;
  iq_entry_t sel_entry;

  reg_addr_t [2*ENTRIES-1:0] q_tags;
  logic      [2*ENTRIES-1:0] q_hit;
  word_t     [2*ENTRIES-1:0] q_data;
  reg_addr_t [1:0]           d_tags;
  logic      [1:0]           d_hit;
  word_t     [1:0]           d_data;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] wr_slot;
  logic             any_ready;
  int               sel_idx;
  logic             out_adv;
  logic             issue_fire;
  logic             disp_fire;
  logic             direct_issue;

  // Source tag 1 of entry i is at CAM index 2*i, and tag 2 is at 2*i+1.
  always_comb begin
    q_tags = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      q_tags[2*i]   = entries[i].src1_tag;
      q_tags[2*i+1] = entries[i].src2_tag;
    end
  end

  assign d_tags[0] = dispatch_inst.src1_tag;
  assign d_tags[1] = dispatch_inst.src2_tag;

  iq_wakeup_cam #(
    .NUM_SRC    (2*ENTRIES),
    .NUM_BYPASS (NUM_BYPASS)
  ) u_queue_cam (
    .tags       (q_tags),
    .bypass_bus (bypass_bus),
    .hit        (q_hit),
    .data       (q_data)
  );

  iq_wakeup_cam #(
    .NUM_SRC    (2),
    .NUM_BYPASS (NUM_BYPASS)
  ) u_dispatch_cam (
    .tags       (d_tags),
    .bypass_bus (bypass_bus),
    .hit        (d_hit),
    .data       (d_data)
  );

  // Each entry with this cycle's wakeup applied. The shift and the write both
  // draw from these copies, so a capture is never lost while an entry moves.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      woken[i] = entries[i];
      if (!entries[i].src1_ready && q_hit[2*i]) begin
        woken[i].src1_ready = 1'b1;
        woken[i].src1_value = q_data[2*i];
      end
      if (!entries[i].src2_ready && q_hit[2*i+1]) begin
        woken[i].src2_ready = 1'b1;
        woken[i].src2_value = q_data[2*i+1];
      end
    end
    woken[ENTRIES] = '0;
  end

  always_comb begin
    disp_woken = entry_from_dispatch(dispatch_inst);
    if (!dispatch_inst.src1_ready && d_hit[0]) begin
      disp_woken.src1_ready = 1'b1;
      disp_woken.src1_value = d_data[0];
    end
    if (!dispatch_inst.src2_ready && d_hit[1]) begin
      disp_woken.src2_ready = 1'b1;
      disp_woken.src2_value = d_data[1];
    end
  end

  // Occupancy and oldest-ready selection come only from registered ready
  // bits. A wakeup therefore makes an entry selectable one cycle later.
  always_comb begin
    count     = '0;
    any_ready = 1'b0;
    sel_idx   = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      count = count + CNT_W'(entries[i].valid);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].valid && entries[i].src1_ready && entries[i].src2_ready) begin
        any_ready = 1'b1;
        sel_idx   = i;
      end
    end
  end

  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (i == sel_idx) begin
        sel_entry = entries[i];
      end
    end
  end

  assign out_adv    = alu_allowin || !issue_to_alu_valid;
  assign issue_fire = out_adv && any_ready;
  assign iq_allowin = (count < CNT_W'(ENTRIES));
  assign disp_fire  = dispatch_valid && iq_allowin;
  assign wr_slot    = count - CNT_W'(issue_fire);

`ifdef ALU_IQ_DIRECT_ISSUE_EN
  assign direct_issue = out_adv && !any_ready && disp_fire &&
                        disp_woken.src1_ready && disp_woken.src2_ready;
`else
  assign direct_issue = 1'b0;
`endif

  // Entries at and above the issued slot take their upper neighbour. The new
  // dispatch lands just past the last surviving entry.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (issue_fire && (i >= sel_idx)) begin
        entries_nxt[i] = woken[i+1];
      end else begin
        entries_nxt[i] = woken[i];
      end
      if (disp_fire && !direct_issue && (i == int'(wr_slot))) begin
        entries_nxt[i] = disp_woken;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i] <= entries_nxt[i];
      end
    end
  end

  // The output register advances when it is empty or being consumed. When it
  // advances and has nothing to load, it goes empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issue_to_alu_valid <= 1'b0;
      issue_inst         <= '0;
    end else if (flush) begin
      issue_to_alu_valid <= 1'b0;
    end else if (out_adv) begin
      if (issue_fire) begin
        issue_to_alu_valid <= 1'b1;
        issue_inst         <= issue_from_entry(sel_entry);
      end else if (direct_issue) begin
        issue_to_alu_valid <= 1'b1;
        issue_inst         <= issue_from_entry(disp_woken);
      end else begin
        issue_to_alu_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue
//   Scoreboard bench for alu_issue_queue. Expected issue packets are queued
//   as stimulus is driven. A monitor pops and compares one packet on every
//   cycle the ALU accepts the output register.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int ENTRIES = 8;
  localparam int NB      = 3;

  logic                        clk;
  logic                        resetn;
  logic                        flush;
  logic                        dispatch_valid;
  logic                        iq_allowin;
  dispatch_to_iq_bus_t         dispatch_inst;
  bypass_bus_t [NB-1:0]        bypass_bus;
  logic                        issue_to_alu_valid;
  logic                        alu_allowin;
  issue_to_execute_bus_t       issue_inst;

  int compared;
  int mismatched;
  issue_to_execute_bus_t sb[$];
  issue_to_execute_bus_t mon_exp;

  alu_issue_queue #(
    .ENTRIES    (ENTRIES),
    .NUM_BYPASS (NB)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .flush              (flush),
    .dispatch_valid     (dispatch_valid),
    .iq_allowin         (iq_allowin),
    .dispatch_inst      (dispatch_inst),
    .bypass_bus         (bypass_bus),
    .issue_to_alu_valid (issue_to_alu_valid),
    .alu_allowin        (alu_allowin),
    .issue_inst         (issue_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic dispatch_to_iq_bus_t makeDisp(
      input logic [31:0] inst, input logic [5:0] dest, input logic [4:0] rob,
      input logic [5:0] t1, input logic r1, input logic [31:0] v1,
      input logic [5:0] t2, input logic r2, input logic [31:0] v2);
    dispatch_to_iq_bus_t d;
    d.inst          = inst;
    d.phy_dest      = dest;
    d.rob_entry_num = rob;
    d.src1_tag      = t1;
    d.src1_ready    = r1;
    d.src1_value    = v1;
    d.src2_tag      = t2;
    d.src2_ready    = r2;
    d.src2_value    = v2;
    return d;
  endfunction

  function automatic issue_to_execute_bus_t makeExp(input dispatch_to_iq_bus_t d,
                                                    input logic [31:0] v1,
                                                    input logic [31:0] v2);
    issue_to_execute_bus_t e;
    e.inst          = d.inst;
    e.phy_dest      = d.phy_dest;
    e.src1_value    = v1;
    e.src2_value    = v2;
    e.rob_entry_num = d.rob_entry_num;
    return e;
  endfunction

  // Called at a negedge: offers one dispatch across the next posedge and
  // returns at the following negedge.
  task automatic applyStimulus(input dispatch_to_iq_bus_t d, output logic accepted);
    dispatch_inst  = d;
    dispatch_valid = 1'b1;
    accepted       = iq_allowin;
    @(posedge clk);
    @(negedge clk);
    dispatch_valid = 1'b0;
  endtask

  task automatic driveBypass(input int idx, input logic [3:0] we,
                             input logic [5:0] tag, input logic [31:0] val);
    bypass_bus[idx].we       = we;
    bypass_bus[idx].phy_dest = tag;
    bypass_bus[idx].result   = val;
    @(posedge clk);
    @(negedge clk);
    bypass_bus = '0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput("drain", 128'(sb.size()), 128'(0));
  endtask

  // Any transfer to the ALU must match the oldest expected packet.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (resetn && !flush && issue_to_alu_valid && alu_allowin) begin
        if (sb.size() == 0) begin
          checkOutput("no_stale_issue", 128'(issue_to_alu_valid), 128'(0));
        end else begin
          mon_exp = sb.pop_front();
          checkOutput("issue_inst", 128'(issue_inst), 128'(mon_exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dispatch_to_iq_bus_t d, da, db;
    logic acc;
    compared       = 0;
    mismatched     = 0;
    resetn         = 1'b0;
    flush          = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_inst  = '0;
    bypass_bus     = '0;
    alu_allowin    = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 128'(issue_to_alu_valid), 128'(0));
    checkOutput("rst_inst", 128'(issue_inst), 128'(0));
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rst_allowin", 128'(iq_allowin), 128'(1));

    // Fully ready ADDU: checks latency and that operands pass unchanged.
    d = makeDisp(32'h0043_1021, 6'd3, 5'd1, 6'd0, 1'b1, 32'h1111_1111,
                 6'd0, 1'b1, 32'h2222_2222);
    sb.push_back(makeExp(d, 32'h1111_1111, 32'h2222_2222));
    applyStimulus(d, acc);
    checkOutput("t1_accept", 128'(acc), 128'(1));
`ifdef ALU_IQ_DIRECT_ISSUE_EN
    checkOutput("t1_lat1_valid", 128'(issue_to_alu_valid), 128'(1));
`else
    checkOutput("t1_lat1_valid", 128'(issue_to_alu_valid), 128'(0));
    @(negedge clk);
    checkOutput("t1_lat2_valid", 128'(issue_to_alu_valid), 128'(1));
`endif
    waitDrain(20);

    // A waits on tag 12, and B is ready: B goes first, then A with 0x1234.
    da = makeDisp(32'hA000_0001, 6'd20, 5'd2, 6'd12, 1'b0, 32'h0,
                  6'd0, 1'b1, 32'h0000_0005);
    db = makeDisp(32'hB000_0002, 6'd21, 5'd3, 6'd0, 1'b1, 32'h0000_00B1,
                  6'd0, 1'b1, 32'h0000_00B2);
    applyStimulus(da, acc);
    sb.push_back(makeExp(db, 32'h0000_00B1, 32'h0000_00B2));
    applyStimulus(db, acc);
    sb.push_back(makeExp(da, 32'h0000_1234, 32'h0000_0005));
    driveBypass(0, 4'b0001, 6'd12, 32'h0000_1234);
    @(negedge clk);
    checkOutput("t2_a_valid", 128'(issue_to_alu_valid), 128'(1));
    checkOutput("t2_a_src1", 128'(issue_inst.src1_value), 128'(32'h0000_1234));
    waitDrain(20);

    // Wakeup arriving in the dispatch cycle is captured by the new entry.
    d = makeDisp(32'hC000_0003, 6'd22, 5'd4, 6'd0, 1'b1, 32'h0000_0077,
                 6'd7, 1'b0, 32'h0);
    sb.push_back(makeExp(d, 32'h0000_0077, 32'h0000_DEAD));
    bypass_bus[1].we       = 4'b0001;
    bypass_bus[1].phy_dest = 6'd7;
    bypass_bus[1].result   = 32'h0000_DEAD;
    applyStimulus(d, acc);
    bypass_bus = '0;
    waitDrain(20);

    // A bypass without we[0] must not wake the source. A real wakeup later must.
    d = makeDisp(32'hD000_0004, 6'd23, 5'd5, 6'd9, 1'b0, 32'h0,
                 6'd0, 1'b1, 32'h0000_0042);
    applyStimulus(d, acc);
    driveBypass(2, 4'b1110, 6'd9, 32'h0BAD_0BAD);
    repeat (3) @(negedge clk);
    checkOutput("t3b_no_we0_wake", 128'(issue_to_alu_valid), 128'(0));
    sb.push_back(makeExp(d, 32'h0000_9999, 32'h0000_0042));
    driveBypass(2, 4'b0001, 6'd9, 32'h0000_9999);
    waitDrain(20);

    // Fill the queue behind a held output register.
    alu_allowin = 1'b0;
    d = makeDisp(32'h5E00_0000, 6'd30, 5'd6, 6'd0, 1'b1, 32'h5, 6'd0, 1'b1, 32'h6);
    sb.push_back(makeExp(d, 32'h5, 32'h6));
    applyStimulus(d, acc);
    @(negedge clk);
    checkOutput("t4_sentinel_valid", 128'(issue_to_alu_valid), 128'(1));
    for (int k = 0; k < 9; k++) begin
      da = makeDisp(32'h1000_0000 + 32'(k), 6'(k + 32), 5'(k + 8), 6'd0, 1'b1,
                    32'h100 + 32'(k), 6'd0, 1'b1, 32'h200 + 32'(k));
      applyStimulus(da, acc);
      if (k < 8) begin
        checkOutput("t4_accept", 128'(acc), 128'(1));
        sb.push_back(makeExp(da, 32'h100 + 32'(k), 32'h200 + 32'(k)));
      end else begin
        checkOutput("t4_full_refused", 128'(acc), 128'(0));
      end
    end
    checkOutput("t4_full_allowin", 128'(iq_allowin), 128'(0));
    checkOutput("t4_hold_inst", 128'(issue_inst), 128'(makeExp(d, 32'h5, 32'h6)));
    alu_allowin = 1'b1;
    for (int k = 0; k < 9; k++) begin
      checkOutput("t4_b2b_valid", 128'(issue_to_alu_valid), 128'(1));
      @(negedge clk);
    end
    checkOutput("t4_drained_valid", 128'(issue_to_alu_valid), 128'(0));
    waitDrain(5);

    // Flush with five queued entries plus a valid output.
    alu_allowin = 1'b0;
    for (int k = 0; k < 6; k++) begin
      da = makeDisp(32'hF000_0000 + 32'(k), 6'd40, 5'(k), 6'd0, 1'b1, 32'h1,
                    6'd0, 1'b1, 32'h2);
      applyStimulus(da, acc);
    end
    checkOutput("t5_pre_valid", 128'(issue_to_alu_valid), 128'(1));
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("t5_flush_valid", 128'(issue_to_alu_valid), 128'(0));
    checkOutput("t5_flush_allowin", 128'(iq_allowin), 128'(1));
    alu_allowin = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("t5_no_stale", 128'(issue_to_alu_valid), 128'(0));
    end
    d = makeDisp(32'h0F0F_0F0F, 6'd41, 5'd9, 6'd0, 1'b1, 32'h3, 6'd0, 1'b1, 32'h4);
    sb.push_back(makeExp(d, 32'h3, 32'h4));
    applyStimulus(d, acc);
    waitDrain(20);

    // Asynchronous reset between clock edges.
    alu_allowin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      da = makeDisp(32'hEE00_0000 + 32'(k), 6'd42, 5'(k), 6'd0, 1'b1, 32'h7,
                    6'd0, 1'b1, 32'h8);
      applyStimulus(da, acc);
    end
    checkOutput("t6_pre_valid", 128'(issue_to_alu_valid), 128'(1));
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t6_async_valid", 128'(issue_to_alu_valid), 128'(0));
    checkOutput("t6_async_inst", 128'(issue_inst), 128'(0));
    @(negedge clk);
    resetn      = 1'b1;
    alu_allowin = 1'b1;
    @(negedge clk);
    checkOutput("t6_allowin", 128'(iq_allowin), 128'(1));
    repeat (4) begin
      @(negedge clk);
      checkOutput("t6_empty", 128'(issue_to_alu_valid), 128'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Data-capture issue queue directly upstream of the ALU execute stage.
- Buffers dispatched ALU instructions and captures source operands from the bypass buses as producers complete.
- Selects the oldest ready entry and drives a registered issue_to_execute_bus_t toward the ALU, handshaking with alu_allowin.
- Entries are compacting: entry 0 is always the oldest.

Parameters:
ENTRIES, 8, queue depth (2..16)
NUM_BYPASS, 3, number of bypass_bus_t wakeup sources (ALU, MDU, LSU)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries and the output register
dispatch_valid  in  1  dispatch offers an instruction
iq_allowin  out  1  queue can accept a dispatch this cycle
dispatch_inst  in  dispatch_to_iq_bus_t  inst, phy_dest, rob_entry_num, srcN_tag, srcN_ready, srcN_value (N=1,2)
bypass_bus  in  NUM_BYPASS x bypass_bus_t  {we[3:0], phy_dest, result} wakeup/data
issue_to_alu_valid  out  1  output register holds a valid instruction
alu_allowin  in  1  ALU accepts the output register this cycle
issue_inst  out  issue_to_execute_bus_t  inst, phy_dest, src1_value, src2_value, rob_entry_num

Behaviour:
- Reset (async, resetn=0): all entry valid bits=0; issue_to_alu_valid=0; issue_inst=0; iq_allowin=1 after release.
- iq_allowin = (count < ENTRIES). It is registered-state based: a slot freed by an issue in the same cycle is not reusable until next cycle.
- Dispatch accepted when dispatch_valid && iq_allowin. The instruction is written to slot [count minus issued this cycle], so the queue stays compacted.
- Wakeup: each bypass whose we[0]=1 is compared with every unready source tag, including the dispatching instruction's own tags in the same cycle.
  - On match: latch the result into srcN_value and set srcN_ready at the clock edge.
  - Tag 0 never matches; dispatch presents such sources already ready.
  - If multiple bypasses match, the lowest bypass index wins (this case cannot occur legally).
- Entry ready = valid && src1_ready && src2_ready, using registered ready bits only. A wakeup in cycle c allows selection in cycle c+1.
- Output register advance: out_adv = alu_allowin || !issue_to_alu_valid.
  - Select occurs only when out_adv. It picks the lowest-index ready entry, loads issue_inst, sets valid=1, removes the entry and shifts higher entries down by one.
  - If out_adv and no entry is ready: issue_to_alu_valid <= 0.
  - If !out_adv: the output register holds and nothing is selected.
- Latency: dispatch accepted in cycle c with both sources ready → issue_to_alu_valid=1 in cycle c+2 (one cycle with ALU_IQ_DIRECT_ISSUE_EN).
- Simultaneous dispatch + issue + wakeup in one cycle: all three apply. Shift, write and capture resolve consistently, so no lost wakeup on shifting entries.
- Full with alu_allowin=0: the queue holds; iq_allowin=0.
- flush: all entries invalid and issue_to_alu_valid <= 0 at the next edge. Flush has priority over dispatch and select.

Optional Feature:
- Macro: ALU_IQ_DIRECT_ISSUE_EN.
- Defined: if out_adv, no queue entry is ready, and the accepted dispatch is fully ready after same-cycle wakeup, the dispatch is loaded straight into the output register. It does not enter the queue; latency is 1 cycle. The iq_allowin rule is unchanged.
- Undefined: every instruction spends at least one cycle in the queue; latency is 2 cycles.

Decomposition:
- Shared cpu package (cpu.svh): dispatch_to_iq_bus_t, iq_entry_t (valid, inst, phy_dest, rob_entry_num, per-source tag/ready/value), IQ_ENTRIES_DEFAULT.
- Reuse bypass_bus_t, issue_to_execute_bus_t and reg_addr_t unchanged.
- One natural sub-module: iq_wakeup_cam. It takes the tag vector plus bypass buses and returns per-source hit and data. It is instantiated for queue entries and the dispatch port.

Test Plan:
- Dispatch ADDU with both sources ready, alu_allowin=1 → issue_to_alu_valid=1 two cycles later (one with direct issue); src values passed unchanged.
- Dispatch A with src1 tag 12 unready, then B fully ready; bypass tag 12 value 0x1234 two cycles later → B issues first; A issues the cycle after wakeup+1 with src1_value=0x1234.
- Dispatch with src2 tag 7 while bypass tag 7 value 0xDEAD is active the same cycle → entry captures 0xDEAD and issues without a further wakeup.
- Hold alu_allowin=0 and dispatch 9 ready instructions → 8 accepted, iq_allowin=0 on the 9th; issue_inst stable. Release → issue in dispatch order 0..7 back-to-back.
- Queue with 5 entries plus a valid output, assert flush → next cycle issue_to_alu_valid=0, iq_allowin=1, and no stale instruction issues afterward.
- Assert resetn=0 mid-operation between clock edges → issue_to_alu_valid drops immediately, without waiting for an edge; the queue is empty after release.
